// File: rtl/stream_fifo_pkg.sv
// Shared helpers for stream_fifo: counter/pointer widths and the wrapping pointer increment.
// Pointers wrap explicitly at DEPTH-1 so any entry count is supported.
package stream_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_ptr.sv
// Wrap-around index register 0..DEPTH-1; advances on inc, clears on rst or clr.
// Latency: new index visible the cycle after inc. No backpressure of its own.
// Clear takes priority over increment.
module stream_fifo_ptr
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PTR_W'(next_ptr(int'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/stream_fifo.sv
// Single-clock FWFT FIFO, any DEPTH, with count and almost-full/empty flags; optional flush via STREAM_FIFO_FLUSH_EN.
// Latency: a word pushed into an empty FIFO appears on out_data the next cycle (no bypass).
// Backpressure: in_ready = !full, computed from count only, so a pop does not free a slot until the next cycle.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef STREAM_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic                  push, pop, full, empty, clr;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef STREAM_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Occupancy is the single source of truth for full/empty and both flags.
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign in_ready     = !full;
  assign out_valid    = !empty;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  stream_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (push),
    .ptr (wr_ptr)
  );

  stream_fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (pop && !push) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo at DEPTH=5; words accepted on push are queued and compared on pop.
module tb_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
`ifdef STREAM_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  logic          acc_push, acc_pop, seen_ov;
  logic [DW-1:0] got, exp_d;
  logic [CW-1:0] seen_cnt;

  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef STREAM_FIFO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  // Drive one cycle at the negedge and record what the next posedge will do.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc_push = iv && in_ready;
    acc_pop  = ordy && out_valid;
    seen_ov  = out_valid;
    seen_cnt = count;
    got      = out_data;
    if (acc_push) sb.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (count !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d rdy=%b vld=%b ae=%b af=%b, want 0 1 0 1 0",
               count, in_ready, out_valid, almost_empty, almost_full);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(8'hA0 + i), 1'b0);
      checks++;
      if (acc_push !== 1'b1) begin
        errors++;
        $display("FAIL fill_push%0d: accepted=%b want 1", i, acc_push);
      end
    end
    drive(1'b1, 8'hA5, 1'b0);
    checks++;
    if (acc_push !== 1'b0) begin
      errors++;
      $display("FAIL fill_sixth_push: accepted=%b want 0", acc_push);
    end
    drive(1'b0, 8'h00, 1'b0);
    checks++;
    if (seen_cnt !== 3'd5 || in_ready !== 1'b0 || almost_full !== 1'b1 || got !== 8'hA0) begin
      errors++;
      $display("FAIL fill_full_state: cnt=%0d rdy=%b af=%b head=%h, want 5 0 1 a0",
               seen_cnt, in_ready, almost_full, got);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++;
      if (!acc_pop || sb.size() == 0) begin
        errors++;
        $display("FAIL drain_pop%0d: popped=%b sb_size=%0d want popped 1", i, acc_pop, sb.size());
      end else begin
        exp_d = sb.pop_front();
        if (got !== exp_d) begin
          errors++;
          $display("FAIL drain_data%0d: got %h want %h", i, got, exp_d);
        end
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (acc_pop !== 1'b0 || seen_cnt !== 0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: vld=%b cnt=%0d ae=%b want 0 0 1", seen_ov, seen_cnt, almost_empty);
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 8'h55, 1'b0);
    checks++;
    if (seen_ov !== 1'b0 || acc_push !== 1'b1) begin
      errors++;
      $display("FAIL latency_same_cycle: vld=%b push=%b want 0 1", seen_ov, acc_push);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (seen_ov !== 1'b1 || got !== 8'h55) begin
      errors++;
      $display("FAIL latency_next_cycle: vld=%b data=%h want 1 55", seen_ov, got);
    end
    if (acc_pop && sb.size() > 0) exp_d = sb.pop_front();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'hB0, 1'b0);
    drive(1'b1, 8'hB1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DW'(8'hC0 + i), 1'b1);
      checks++;
      if (seen_cnt !== 3'd2 || !acc_push || !acc_pop) begin
        errors++;
        $display("FAIL b2b_cnt%0d: cnt=%0d push=%b pop=%b want 2 1 1", i, seen_cnt, acc_push, acc_pop);
      end
      if (acc_pop && sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++;
        if (got !== exp_d) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h want %h", i, got, exp_d);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (acc_pop && sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++;
        if (got !== exp_d) begin
          errors++;
          $display("FAIL b2b_tail%0d: got %h want %h", i, got, exp_d);
        end
      end
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(8'hD0 + i), 1'b0);
    drive(1'b1, 8'hD5, 1'b1);
    checks++;
    if (acc_push !== 1'b0 || acc_pop !== 1'b1) begin
      errors++;
      $display("FAIL full_pop_push: push=%b pop=%b want 0 1", acc_push, acc_pop);
    end
    if (acc_pop && sb.size() > 0) exp_d = sb.pop_front();
    drive(1'b1, 8'hD5, 1'b0);
    checks++;
    if (seen_cnt !== 3'd4 || acc_push !== 1'b1) begin
      errors++;
      $display("FAIL full_push_next: cnt=%0d push=%b want 4 1", seen_cnt, acc_push);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (acc_pop && sb.size() > 0) begin
        exp_d = sb.pop_front();
        checks++;
        if (got !== exp_d) begin
          errors++;
          $display("FAIL full_drain%0d: got %h want %h", i, got, exp_d);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_drain_left: remaining=%0d want 0", sb.size());
    end
  endtask

  task automatic test_clear(input bit use_flush);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'hE0 + i), 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL clear_pre%0d: cnt=%0d want 3", use_flush, count);
    end
`ifdef STREAM_FIFO_FLUSH_EN
    if (use_flush) flush = 1'b1; else rst = 1'b1;
`else
    rst = 1'b1;
`endif
    in_valid = 1'b1;
    in_data  = 8'hEE;
    @(negedge clk);
    rst = 1'b0;
`ifdef STREAM_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    in_valid = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL clear_state%0d: cnt=%0d vld=%b ae=%b want 0 0 1",
               use_flush, count, out_valid, almost_empty);
    end
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (!acc_pop || got !== 8'h3C) begin
      errors++;
      $display("FAIL clear_after%0d: pop=%b data=%h want 1 3c", use_flush, acc_pop, got);
    end
    if (acc_pop && sb.size() > 0) exp_d = sb.pop_front();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_back_to_back();
    test_full_pop_push();
    test_clear(1'b0);
`ifdef STREAM_FIFO_FLUSH_EN
    test_clear(1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
